key_repeat: RTL and testbench
=============================

// Module: key_repeat
// PURPOSE
//  Auto-repeat stage that sits directly downstream of the button debouncer.
//  It consumes the debounced button levels (btnsignal[4:0]).
//  Each button produces one pulse on press. If the button is held past a hold delay,
//  it then produces a train of pulses at a fixed rate.
//  The menu/value-entry logic uses key_pulse in place of the single-shot btnpulse.
// PARAMETERS
//  TICK_DIV    50000  clk cycles per timing tick (1 ms at 50 MHz); >=2
//  HOLD_TICKS  500    ticks from press to first repeat pulse; 1..2**CNT_W-1
//  RATE_TICKS  100    ticks between repeat pulses; 1..2**CNT_W-1
//  CNT_W       10     width of each per-button tick counter
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  btnsignal  in   5  debounced button levels, 1 = pressed (synchronous to clk)
//  key_pulse  out  5  one-clk pulse: initial press or auto-repeat
//  repeating  out  5  1 while button is in REPEAT state
//  longpress  out  5  one-clk pulse on release after repeat (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, all states IDLE, all counters 0, prescaler 0.
//  - Prescaler pre_cnt (16 bit) counts 0..TICK_DIV-1 and wraps.
//    tick=1 for one clk when pre_cnt==TICK_DIV-1.
//  - The prescaler is shared by all buttons and runs freely (it is not restarted by a press).
//  - Per button i: independent FSM {IDLE, DELAY, REPEAT} with counter cnt[i].
//  - IDLE:
//    - btnsignal[i]=1 -> key_pulse[i]=1 next clk, go DELAY, cnt=0.
//  - DELAY:
//    - btnsignal[i]=0 -> IDLE, no pulse.
//    - else on tick: if cnt==HOLD_TICKS-1 -> pulse, go REPEAT, cnt=0; otherwise cnt++.
//  - REPEAT:
//    - btnsignal[i]=0 -> IDLE.
//    - else on tick: if cnt==RATE_TICKS-1 -> pulse, cnt=0; otherwise cnt++.
//  - Outputs are registered. key_pulse appears 1 clk after the triggering sampled condition.
//  - repeating[i] is registered, = (state==REPEAT).
//  - Release has priority over a tick in the same clk: no pulse is issued, and the FSM goes to IDLE.
//  - A press in the same clk as a tick: initial pulse only; cnt starts at 0.
//    That tick is not counted.
//  - First repeat pulse lands between HOLD_TICKS-1 and HOLD_TICKS ticks after the press.
//    The jitter is at most TICK_DIV clk because of the free-running prescaler.
//  - Repeat spacing is exactly RATE_TICKS*TICK_DIV clk.
//  - Counters never exceed the compare value, so they never wrap.
//  - Buttons are fully independent. Several key_pulse bits may assert in the same clk.
//  - Reset asserted mid-hold: outputs drop to 0 immediately.
//    After reset deasserts with the button still held, the block treats it as a new press.
// CONFIGURATION
//  Macro KEY_REPEAT_LONGPRESS_EN controls the longpress output.
//  - Defined: on a release from REPEAT, longpress[i]=1 for one clk (same clk as IDLE entry).
//    A release from DELAY gives no longpress.
//  - Undefined: longpress is tied to 5'b0 and no extra logic is built.
//  - All other behaviour is identical in both builds.
// TESTING  (TICK_DIV=4, HOLD_TICKS=3, RATE_TICKS=2, CNT_W=4)
//  1. Reset: hold rst_n=0 with btnsignal=5'h1F -> key_pulse, repeating, longpress all 0.
//     Release reset with buttons held -> one initial pulse on all 5 bits.
//  2. Tap: btn0=1 for 3 clk, then 0 -> exactly one key_pulse[0], 1 clk after rise.
//     repeating[0] stays 0 and longpress stays 0.
//  3. Hold btn2 for 60 clk:
//     - initial pulse 1 clk after rise;
//     - repeat pulse 9..12 clk after rise, with repeating[2]=1 from then on;
//     - further pulses every 8 clk;
//     - with the macro, one longpress[2] pulse on release.
//  4. Release on a tick clk: drop btn2 in the clk where tick=1 and cnt==RATE_TICKS-1
//     -> no key_pulse, and IDLE is entered next clk.
//  5. Independence: btn1 pressed 5 clk after btn3, both held
//     -> each follows its own timing from its own press, with no cross-talk.
//  6. Reset mid-REPEAT: pulse rst_n low for 2 clk with btn4 held
//     -> all outputs 0 during reset; a fresh initial pulse follows the deassert.

Source files
------------

// File: rtl/key_repeat.sv
// Per-button auto-repeat: one pulse on press, then a pulse train while held.
// Define KEY_REPEAT_LONGPRESS_EN to build the longpress-on-release output.
module key_repeat #(
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 500,
    parameter int RATE_TICKS = 100,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btnsignal,
    output logic [4:0] key_pulse,
    output logic [4:0] repeating,
    output logic [4:0] longpress
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    localparam logic [15:0]      PRE_LAST  = 16'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_TICKS - 1);

    logic [15:0]      pre_cnt_q, pre_cnt_d;
    logic             tick;
    state_t           state_q [5];
    state_t           state_d [5];
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       key_pulse_q, key_pulse_d;
    logic [4:0]       repeating_q, repeating_d;
`ifdef KEY_REPEAT_LONGPRESS_EN
    logic [4:0]       longpress_q, longpress_d;
`endif

    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
        key_pulse_d = '0;
        repeating_d = '0;
`ifdef KEY_REPEAT_LONGPRESS_EN
        longpress_d = '0;
`endif
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            // Release wins over a coincident tick; a press ignores its tick.
            case (state_q[i])
                IDLE: begin
                    if (btnsignal[i]) begin
                        key_pulse_d[i] = 1'b1;
                        state_d[i]     = DELAY;
                        cnt_d[i]       = '0;
                    end
                end
                DELAY: begin
                    if (!btnsignal[i]) begin
                        state_d[i] = IDLE;
                    end else if (tick) begin
                        if (cnt_q[i] == HOLD_LAST) begin
                            key_pulse_d[i] = 1'b1;
                            state_d[i]     = REPEAT;
                            cnt_d[i]       = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!btnsignal[i]) begin
                        state_d[i] = IDLE;
`ifdef KEY_REPEAT_LONGPRESS_EN
                        longpress_d[i] = 1'b1;
`endif
                    end else if (tick) begin
                        if (cnt_q[i] == RATE_LAST) begin
                            key_pulse_d[i] = 1'b1;
                            cnt_d[i]       = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            repeating_d[i] = (state_d[i] == REPEAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q   <= '0;
            key_pulse_q <= '0;
            repeating_q <= '0;
`ifdef KEY_REPEAT_LONGPRESS_EN
            longpress_q <= '0;
`endif
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            key_pulse_q <= key_pulse_d;
            repeating_q <= repeating_d;
`ifdef KEY_REPEAT_LONGPRESS_EN
            longpress_q <= longpress_d;
`endif
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign key_pulse = key_pulse_q;
    assign repeating = repeating_q;
`ifdef KEY_REPEAT_LONGPRESS_EN
    assign longpress = longpress_q;
`else
    assign longpress = '0;
`endif

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: directed scenarios plus random button traffic
// compared against a tick-counting reference model.
module tb_key_repeat;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam int RT = 2;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic [4:0] kp, rp, lp;

    always #5 clk = ~clk;

    key_repeat #(
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT),
        .RATE_TICKS(RT),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btnsignal(btn),
        .key_pulse(kp),
        .repeating(rp),
        .longpress(lp)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: ticks seen while held since the press.
    int         ncyc;
    bit         held [5];
    int         ticks [5];
    logic [4:0] exp_kp, exp_rp, exp_lp;
    bit         last_tick;

`ifdef KEY_REPEAT_LONGPRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    task automatic model_reset();
        ncyc = 0;
        for (int i = 0; i < 5; i++) begin
            held[i]  = 1'b0;
            ticks[i] = 0;
        end
        exp_kp = '0;
        exp_rp = '0;
        exp_lp = '0;
    endtask

    task automatic step();
        bit tk;
        tk = ((ncyc % TD) == TD - 1);
        last_tick = tk;
        ncyc++;
        exp_kp = '0;
        exp_lp = '0;
        exp_rp = '0;
        for (int i = 0; i < 5; i++) begin
            if (!held[i]) begin
                if (btn[i]) begin
                    held[i]   = 1'b1;
                    ticks[i]  = 0;
                    exp_kp[i] = 1'b1;
                end
            end else if (!btn[i]) begin
                exp_lp[i] = LP_ON && (ticks[i] >= HT);
                held[i]   = 1'b0;
            end else if (tk) begin
                ticks[i]++;
                if (ticks[i] >= HT && ((ticks[i] - HT) % RT) == 0)
                    exp_kp[i] = 1'b1;
            end
            exp_rp[i] = held[i] && (ticks[i] >= HT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn = 5'h1F;
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({kp, rp, lp} !== 15'h0) begin
                failures++;
                $display("FAIL reset_hold kp=%h rp=%h lp=%h want 0", kp, rp, lp);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (kp !== 5'h1F || rp !== 5'h0) begin
            failures++;
            $display("FAIL reset_release kp=%h rp=%h want kp=1f rp=0", kp, rp);
        end
        btn = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (kp !== exp_kp || rp !== exp_rp || lp !== exp_lp) begin
                failures++;
                $display("FAIL reset_settle kp=%h/%h rp=%h/%h lp=%h/%h",
                         kp, exp_kp, rp, exp_rp, lp, exp_lp);
            end
        end
    endtask

    task automatic test_tap();
        int npulse = 0;
        int at = -1;
        btn[0] = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            if (s == 4) btn[0] = 1'b0;
            step();
            if (kp[0]) begin
                npulse++;
                at = s;
            end
            checks++;
            if (kp !== exp_kp || rp[0] !== 1'b0 || lp !== 5'h0) begin
                failures++;
                $display("FAIL tap step=%0d kp=%h/%h rp=%h lp=%h", s, kp, exp_kp, rp, lp);
            end
        end
        checks++;
        if (npulse !== 1 || at !== 1) begin
            failures++;
            $display("FAIL tap_count pulses=%0d at=%0d want 1 at 1", npulse, at);
        end
    endtask

    task automatic test_hold();
        int q[$];
        bit rep_seen = 1'b0;
        btn[2] = 1'b1;
        for (int s = 1; s <= 60; s++) begin
            step();
            if (kp[2]) begin
                q.push_back(s);
                if (q.size() == 2) rep_seen = 1'b1;
            end
            checks++;
            if (kp !== exp_kp || rp !== exp_rp || lp !== exp_lp ||
                (rep_seen && rp[2] !== 1'b1)) begin
                failures++;
                $display("FAIL hold step=%0d kp=%h/%h rp=%h/%h lp=%h/%h",
                         s, kp, exp_kp, rp, exp_rp, lp, exp_lp);
            end
        end
        checks++;
        if (q.size() < 3) begin
            failures++;
            $display("FAIL hold_pulses count=%0d want >=3", q.size());
        end else begin
            checks++;
            if (q[0] != 1 || q[1] - q[0] < 9 || q[1] - q[0] > 12) begin
                failures++;
                $display("FAIL hold_first first=%0d delay=%0d want 1 and 9..12",
                         q[0], q[1] - q[0]);
            end
            for (int k = 2; k < q.size(); k++) begin
                checks++;
                if (q[k] - q[k-1] != RT * TD) begin
                    failures++;
                    $display("FAIL hold_rate gap=%0d want %0d", q[k] - q[k-1], RT * TD);
                end
            end
        end
        btn[2] = 1'b0;
        step();
        checks++;
        if (lp[2] !== LP_ON || rp[2] !== 1'b0 || kp[2] !== 1'b0) begin
            failures++;
            $display("FAIL hold_release lp=%b want %b rp=%b kp=%b", lp[2], LP_ON, rp[2], kp[2]);
        end
        step();
        checks++;
        if (lp !== 5'h0) begin
            failures++;
            $display("FAIL longpress_width lp=%h want 0", lp);
        end
    endtask

    task automatic test_release_on_tick();
        bit found = 1'b0;
        btn[2] = 1'b1;
        for (int s = 0; s < 100 && !found; s++) begin
            if (held[2] && ticks[2] >= HT && ((ticks[2] + 1 - HT) % RT) == 0 &&
                (ncyc % TD) == TD - 1) begin
                found  = 1'b1;
                btn[2] = 1'b0;
                step();
                checks++;
                if (kp[2] !== 1'b0 || rp[2] !== 1'b0 || !last_tick) begin
                    failures++;
                    $display("FAIL release_tick kp=%b rp=%b want 0 0", kp[2], rp[2]);
                end
            end else begin
                step();
                checks++;
                if (kp !== exp_kp || rp !== exp_rp || lp !== exp_lp) begin
                    failures++;
                    $display("FAIL release_tick_run kp=%h/%h rp=%h/%h", kp, exp_kp, rp, exp_rp);
                end
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL release_tick_timeout found=0 want 1");
        end
        btn = '0;
        step();
    endtask

    task automatic test_independence();
        int p1[$];
        int p3[$];
        int len;
        len = $urandom_range(30, 50);
        btn[3] = 1'b1;
        for (int s = 1; s <= len + 5; s++) begin
            if (s == 6) btn[1] = 1'b1;
            step();
            if (kp[3]) p3.push_back(s);
            if (kp[1]) p1.push_back(s - 5);
            checks++;
            if (kp !== exp_kp || rp !== exp_rp || lp !== exp_lp) begin
                failures++;
                $display("FAIL indep step=%0d kp=%h/%h rp=%h/%h lp=%h/%h",
                         s, kp, exp_kp, rp, exp_rp, lp, exp_lp);
            end
        end
        checks++;
        if (p1.size() < 2 || p3.size() < 2 || p1[0] != 1 || p3[0] != 1 ||
            p1[1] - p1[0] < 9 || p1[1] - p1[0] > 12 ||
            p3[1] - p3[0] < 9 || p3[1] - p3[0] > 12) begin
            failures++;
            $display("FAIL indep_timing n1=%0d n3=%0d want >=2 each, delay 9..12",
                     p1.size(), p3.size());
        end
        btn = '0;
        step();
        step();
    endtask

    task automatic test_reset_mid_repeat();
        bit got = 1'b0;
        btn[4] = 1'b1;
        for (int s = 0; s < 40 && !got; s++) begin
            step();
            got = (rp[4] === 1'b1);
        end
        checks++;
        if (!got || exp_rp[4] !== 1'b1) begin
            failures++;
            $display("FAIL midrep_reach rp=%b want 1", rp[4]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({kp, rp, lp} !== 15'h0) begin
            failures++;
            $display("FAIL midrep_async kp=%h rp=%h lp=%h want 0", kp, rp, lp);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({kp, rp, lp} !== 15'h0) begin
            failures++;
            $display("FAIL midrep_hold kp=%h rp=%h lp=%h want 0", kp, rp, lp);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (kp !== 5'h10 || rp !== 5'h0 || lp !== 5'h0) begin
            failures++;
            $display("FAIL midrep_fresh kp=%h rp=%h lp=%h want 10 0 0", kp, rp, lp);
        end
        btn = '0;
        step();
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
            step();
            checks++;
            if (kp !== exp_kp || rp !== exp_rp || lp !== exp_lp) begin
                failures++;
                $display("FAIL random step=%0d btn=%h kp=%h/%h rp=%h/%h lp=%h/%h",
                         s, btn, kp, exp_kp, rp, exp_rp, lp, exp_lp);
            end
        end
        btn = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold();
        test_release_on_tick();
        test_independence();
        test_reset_mid_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
